// File: rtl/game_state_ctrl.sv
// Game flow controller: start menu, pre-game countdown, play, and game-over screens.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// MENU      | waiting for a click on the start button with a class chosen
// COUNTDOWN | counting START_FRAMES frames down before play begins
// PLAYING   | game running; watching player/boss death flags
// LOST      | player died; held for END_FRAMES frames, then click to exit
// WON       | boss died; held for END_FRAMES frames, then click to exit
module game_state_ctrl #(
    parameter int unsigned BTN_X        = 387,
    parameter int unsigned BTN_Y        = 231,
    parameter int unsigned BTN_W        = 250,
    parameter int unsigned BTN_H        = 75,
    parameter int unsigned START_FRAMES = 60,
    parameter int unsigned END_FRAMES   = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [11:0] mouse_x,
    input  logic [11:0] mouse_y,
    input  logic        mouse_clicked,
    input  logic [1:0]  char_class,
    input  logic        player_dead,
    input  logic        boss_dead,
    output logic [1:0]  game_active,
    output logic [7:0]  countdown,
    output logic        game_restart
);

    typedef enum logic [2:0] {
        MENU,
        COUNTDOWN,
        PLAYING,
        LOST,
        WON
    } state_t;

    // Button bounds as 12-bit values; the right/bottom edges are exclusive.
    localparam logic [11:0] X_LO = 12'(BTN_X);
    localparam logic [11:0] X_HI = 12'(BTN_X + BTN_W);
    localparam logic [11:0] Y_LO = 12'(BTN_Y);
    localparam logic [11:0] Y_HI = 12'(BTN_Y + BTN_H);

    localparam logic [7:0] START_LD = 8'(START_FRAMES);
    localparam logic [7:0] END_LD   = 8'(END_FRAMES);

    state_t     state;
    logic [7:0] frame_cnt;
    logic       btn_hit;
    logic       class_ok;

    // Start-button hit test and class validity for the menu transition.
    always_comb begin
        btn_hit  = (mouse_x >= X_LO) && (mouse_x < X_HI) &&
                   (mouse_y >= Y_LO) && (mouse_y < Y_HI);
        class_ok = (char_class == 2'd1) || (char_class == 2'd2);
    end

    // State machine with frame counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= MENU;
            frame_cnt    <= 8'd0;
            game_active  <= 2'd0;
            countdown    <= 8'd0;
            game_restart <= 1'b0;
        end else begin
            game_restart <= 1'b0;
            case (state)
                MENU: begin
                    if (mouse_clicked && btn_hit && class_ok) begin
                        state       <= COUNTDOWN;
                        frame_cnt   <= START_LD;
                        countdown   <= START_LD;
                        game_active <= 2'd0;
                    end
                end
                COUNTDOWN: begin
                    // Deselecting the class aborts quietly; it is not a restart.
                    if (char_class == 2'd0) begin
                        state       <= MENU;
                        frame_cnt   <= 8'd0;
                        countdown   <= 8'd0;
                        game_active <= 2'd0;
                    end else if (frame_tick) begin
                        if (frame_cnt == 8'd1) begin
                            state       <= PLAYING;
                            frame_cnt   <= 8'd0;
                            countdown   <= 8'd0;
                            game_active <= 2'd1;
                        end else begin
                            frame_cnt <= frame_cnt - 8'd1;
                            countdown <= frame_cnt - 8'd1;
                        end
                    end
                end
                PLAYING: begin
                    // Player death wins a tie with boss death.
                    if (player_dead) begin
                        state       <= LOST;
                        frame_cnt   <= END_LD;
                        game_active <= 2'd2;
                    end else if (boss_dead) begin
                        state       <= WON;
                        frame_cnt   <= END_LD;
                        game_active <= 2'd3;
                    end
                end
                LOST, WON: begin
                    if (frame_cnt == 8'd0) begin
                        if (mouse_clicked) begin
                            state        <= MENU;
                            game_active  <= 2'd0;
                            countdown    <= 8'd0;
                            game_restart <= 1'b1;
                        end
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt - 8'd1;
                    end
                end
                default: begin
                    state       <= MENU;
                    frame_cnt   <= 8'd0;
                    countdown   <= 8'd0;
                    game_active <= 2'd0;
                end
            endcase
        end
    end

endmodule
